// File: rtl/ptr_feeder.sv
// Frame FIFO feeding the ptr reader: each fe_data_rq assertion delivers at most one
// 8-bit frame as a single s_write strobe, DELAY+1 cycles after the request is accepted.
//
// state  | meaning
// IDLE   | no request pending
// STARVE | request seen with FIFO empty, waiting for data
// WAIT   | delay counter running toward delivery
// WRITE  | s_write high for one cycle, FIFO head popped
// HOLD   | frame delivered, waiting for fe_data_rq to drop
module ptr_feeder #(
   parameter int DEPTH = 16,
   parameter int DELAY = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    h_write,
   input  logic [7:0]              h_writedata,
   input  logic                    h_flush,
   output logic                    h_full,
   output logic [$clog2(DEPTH):0]  h_level,
   output logic                    h_overflow,
   output logic                    h_starve,
   input  logic                    h_clr_flags,
   output logic [15:0]             h_count,
   input  logic                    fe_data_rq,
   output logic                    s_write,
   output logic [31:0]             s_writedata
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [2:0] {IDLE, STARVE, WAIT, WRITE, HOLD} state_t;

   state_t          state;
   logic [15:0]     cnt;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [7:0]      mem [DEPTH];
   logic            pop;
   logic            push;
   logic            empty;

   assign h_full = (h_level == LW'(DEPTH));
   assign empty  = (h_level == '0);

   // A pop while full frees the slot the simultaneous push lands in.
   always_comb begin
      pop  = (state == WRITE);
      push = h_write && (!h_full || pop) && !h_flush;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= h_writedata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         h_level     <= '0;
         h_overflow  <= 1'b0;
         h_starve    <= 1'b0;
         h_count     <= '0;
         s_write     <= 1'b0;
         s_writedata <= '0;
      end else begin
         s_write     <= 1'b0;
         s_writedata <= '0;

         if (h_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            h_level <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            h_level <= h_level + LW'(push) - LW'(pop);
         end

         if (h_write && h_full && !pop && !h_flush) h_overflow <= 1'b1;
         else if (h_clr_flags)                      h_overflow <= 1'b0;

         if (state == IDLE && fe_data_rq && empty) h_starve <= 1'b1;
         else if (h_clr_flags)                     h_starve <= 1'b0;

         // WAIT is only entered with data that a same-cycle flush is not about to discard.
         case (state)
            IDLE: begin
               if (fe_data_rq) begin
                  if (empty) begin
                     state <= STARVE;
                  end else if (!h_flush) begin
                     state <= WAIT;
                     cnt   <= 16'(DELAY - 1);
                  end
               end
            end
            STARVE: begin
               if (!fe_data_rq) begin
                  state <= IDLE;
               end else if (!empty && !h_flush) begin
                  state <= WAIT;
                  cnt   <= 16'(DELAY - 1);
               end
            end
            WAIT: begin
               if (!fe_data_rq || h_flush) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  state       <= WRITE;
                  s_write     <= 1'b1;
                  s_writedata <= {24'd0, mem[rd_ptr]};
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WRITE: begin
               h_count <= h_count + 1'b1;
               state   <= HOLD;
            end
            HOLD: begin
               if (!fe_data_rq) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ptr_feeder.sv
// Directed bench for ptr_feeder with DEPTH=4, DELAY=5; expected values computed by hand.
module tb_ptr_feeder;

   localparam int DEPTH = 4;
   localparam int DELAY = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic        h_write;
   logic [7:0]  h_writedata;
   logic        h_flush;
   logic        h_full;
   logic [2:0]  h_level;
   logic        h_overflow;
   logic        h_starve;
   logic        h_clr_flags;
   logic [15:0] h_count;
   logic        fe_data_rq;
   logic        s_write;
   logic [31:0] s_writedata;

   int errors = 0;
   int checks = 0;

   ptr_feeder #(.DEPTH(DEPTH), .DELAY(DELAY)) dut (
      .clk(clk), .reset(reset), .h_write(h_write), .h_writedata(h_writedata),
      .h_flush(h_flush), .h_full(h_full), .h_level(h_level), .h_overflow(h_overflow),
      .h_starve(h_starve), .h_clr_flags(h_clr_flags), .h_count(h_count),
      .fe_data_rq(fe_data_rq), .s_write(s_write), .s_writedata(s_writedata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      h_write = 1'b1; h_writedata = d;
      tick();
      h_write = 1'b0;
   endtask

   task automatic wait_strobe(input int max, output int cyc, output logic [31:0] d);
      bit found = 0;
      cyc = -1; d = '0;
      for (int i = 1; i <= max && !found; i++) begin
         tick();
         if (s_write) begin found = 1; cyc = i; d = s_writedata; end
      end
   endtask

   task automatic count_strobes(input int n, output int k);
      k = 0;
      repeat (n) begin
         tick();
         if (s_write) k++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checks++; if (h_level !== 3'd0)    begin errors++; $display("FAIL reset_level got %0d exp 0", h_level); end
      checks++; if (h_full !== 1'b0)     begin errors++; $display("FAIL reset_full got %0b exp 0", h_full); end
      checks++; if (h_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", h_overflow); end
      checks++; if (h_starve !== 1'b0)   begin errors++; $display("FAIL reset_starve got %0b exp 0", h_starve); end
      checks++; if (h_count !== 16'd0)   begin errors++; $display("FAIL reset_count got %0d exp 0", h_count); end
      checks++; if (s_write !== 1'b0)    begin errors++; $display("FAIL reset_swrite got %0b exp 0", s_write); end
      checks++; if (s_writedata !== 32'd0) begin errors++; $display("FAIL reset_sdata got %h exp 0", s_writedata); end
   endtask

   task automatic test_single();
      int cyc; int k; logic [31:0] d;
      push(8'hBF);
      checks++; if (h_level !== 3'd1) begin errors++; $display("FAIL single_level_pre got %0d exp 1", h_level); end
      fe_data_rq = 1'b1;
      wait_strobe(40, cyc, d);
      checks++; if (cyc !== DELAY + 1) begin errors++; $display("FAIL single_latency got %0d exp %0d", cyc, DELAY + 1); end
      checks++; if (d !== 32'h0000_00BF) begin errors++; $display("FAIL single_data got %h exp 000000bf", d); end
      tick();
      checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %0b exp 0", s_write); end
      checks++; if (h_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", h_count); end
      checks++; if (h_level !== 3'd0) begin errors++; $display("FAIL single_level got %0d exp 0", h_level); end
      count_strobes(10, k);
      checks++; if (k !== 0) begin errors++; $display("FAIL single_hold got %0d strobes exp 0", k); end
      fe_data_rq = 1'b0;
      tick(); tick();
   endtask

   task automatic test_multi();
      int cyc; int k; logic [31:0] d;
      logic [7:0] exp_d [3] = '{8'hB6, 8'hAD, 8'hA4};
      push(8'hB6); push(8'hAD); push(8'hA4);
      checks++; if (h_level !== 3'd3) begin errors++; $display("FAIL multi_level_pre got %0d exp 3", h_level); end
      for (int i = 0; i < 3; i++) begin
         fe_data_rq = 1'b1;
         wait_strobe(40, cyc, d);
         checks++; if (d !== {24'd0, exp_d[i]}) begin errors++; $display("FAIL multi_data%0d got %h exp %h", i, d, exp_d[i]); end
         checks++; if (cyc !== DELAY + 1) begin errors++; $display("FAIL multi_latency%0d got %0d exp %0d", i, cyc, DELAY + 1); end
         if (i == 0) begin
            count_strobes(12, k);
            checks++; if (k !== 0) begin errors++; $display("FAIL multi_hold got %0d strobes exp 0", k); end
         end
         fe_data_rq = 1'b0;
         tick(); tick();
      end
      checks++; if (h_count !== 16'd4) begin errors++; $display("FAIL multi_count got %0d exp 4", h_count); end
      checks++; if (h_level !== 3'd0) begin errors++; $display("FAIL multi_level got %0d exp 0", h_level); end
   endtask

   task automatic test_starve();
      int cyc; int k; logic [31:0] d;
      fe_data_rq = 1'b1;
      count_strobes(50, k);
      checks++; if (k !== 0) begin errors++; $display("FAIL starve_nostrobe got %0d exp 0", k); end
      checks++; if (h_starve !== 1'b1) begin errors++; $display("FAIL starve_flag got %0b exp 1", h_starve); end
      push(8'h55);
      wait_strobe(40, cyc, d);
      checks++; if (cyc !== DELAY + 1) begin errors++; $display("FAIL starve_latency got %0d exp %0d", cyc, DELAY + 1); end
      checks++; if (d !== 32'h0000_0055) begin errors++; $display("FAIL starve_data got %h exp 00000055", d); end
      fe_data_rq = 1'b0;
      tick(); tick();
      h_clr_flags = 1'b1;
      tick();
      h_clr_flags = 1'b0;
      checks++; if (h_starve !== 1'b0) begin errors++; $display("FAIL starve_clear got %0b exp 0", h_starve); end
      checks++; if (h_count !== 16'd5) begin errors++; $display("FAIL starve_count got %0d exp 5", h_count); end
   endtask

   task automatic test_full();
      int cyc; logic [31:0] d;
      h_write = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         h_writedata = 8'h10 + 8'(i);
         tick();
      end
      h_write = 1'b0;
      checks++; if (h_full !== 1'b1)     begin errors++; $display("FAIL full_flag got %0b exp 1", h_full); end
      checks++; if (h_level !== 3'd4)    begin errors++; $display("FAIL full_level got %0d exp 4", h_level); end
      checks++; if (h_overflow !== 1'b1) begin errors++; $display("FAIL full_ovf got %0b exp 1", h_overflow); end
      h_clr_flags = 1'b1;
      tick();
      h_clr_flags = 1'b0;
      checks++; if (h_overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_clear got %0b exp 0", h_overflow); end
      fe_data_rq = 1'b1;
      wait_strobe(40, cyc, d);
      checks++; if (d !== 32'h0000_0010) begin errors++; $display("FAIL full_head got %h exp 00000010", d); end
      push(8'h20);
      checks++; if (h_level !== 3'd4)    begin errors++; $display("FAIL full_pushpop_level got %0d exp 4", h_level); end
      checks++; if (h_overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf got %0b exp 0", h_overflow); end
      checks++; if (h_count !== 16'd6)   begin errors++; $display("FAIL full_count got %0d exp 6", h_count); end
      fe_data_rq = 1'b0;
      tick();
      h_flush = 1'b1; h_write = 1'b1; h_writedata = 8'hEE;
      tick();
      h_flush = 1'b0; h_write = 1'b0;
      checks++; if (h_level !== 3'd0) begin errors++; $display("FAIL flush_push_level got %0d exp 0", h_level); end
      checks++; if (h_full !== 1'b0)  begin errors++; $display("FAIL flush_push_full got %0b exp 0", h_full); end
      tick();
   endtask

   task automatic test_abort();
      int cyc; int k; int k2; logic [31:0] d;
      push(8'h77);
      fe_data_rq = 1'b1;
      count_strobes(3, k);
      fe_data_rq = 1'b0;
      count_strobes(2 * DELAY, k2);
      checks++; if (k + k2 !== 0)      begin errors++; $display("FAIL abort_nostrobe got %0d exp 0", k + k2); end
      checks++; if (h_level !== 3'd1)  begin errors++; $display("FAIL abort_level got %0d exp 1", h_level); end
      checks++; if (h_count !== 16'd6) begin errors++; $display("FAIL abort_count got %0d exp 6", h_count); end
      fe_data_rq = 1'b1;
      wait_strobe(40, cyc, d);
      checks++; if (cyc !== DELAY + 1) begin errors++; $display("FAIL abort_relatency got %0d exp %0d", cyc, DELAY + 1); end
      checks++; if (d !== 32'h0000_0077) begin errors++; $display("FAIL abort_data got %h exp 00000077", d); end
      fe_data_rq = 1'b0;
      tick(); tick();
   endtask

   task automatic test_flush_wait();
      int k; int k2;
      push(8'h99);
      fe_data_rq = 1'b1;
      count_strobes(3, k);
      h_flush = 1'b1;
      tick();
      h_flush = 1'b0;
      checks++; if (h_level !== 3'd0) begin errors++; $display("FAIL flushwait_level got %0d exp 0", h_level); end
      count_strobes(2 * DELAY, k2);
      checks++; if (k + k2 !== 0) begin errors++; $display("FAIL flushwait_nostrobe got %0d exp 0", k + k2); end
      checks++; if (h_count !== 16'd7) begin errors++; $display("FAIL flushwait_count got %0d exp 7", h_count); end
      fe_data_rq = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      int cyc; int k; logic [31:0] d;
      push(8'h42);
      fe_data_rq = 1'b1;
      tick(); tick(); tick();
      reset = 1'b1; fe_data_rq = 1'b0;
      tick();
      reset = 1'b0;
      checks++; if (s_write !== 1'b0)      begin errors++; $display("FAIL rstwait_swrite got %0b exp 0", s_write); end
      checks++; if (s_writedata !== 32'd0) begin errors++; $display("FAIL rstwait_sdata got %h exp 0", s_writedata); end
      checks++; if (h_level !== 3'd0)      begin errors++; $display("FAIL rstwait_level got %0d exp 0", h_level); end
      checks++; if (h_count !== 16'd0)     begin errors++; $display("FAIL rstwait_count got %0d exp 0", h_count); end
      checks++; if (h_starve !== 1'b0 || h_overflow !== 1'b0 || h_full !== 1'b0)
         begin errors++; $display("FAIL rstwait_flags got %b%b%b exp 000", h_starve, h_overflow, h_full); end
      count_strobes(2 * DELAY, k);
      checks++; if (k !== 0) begin errors++; $display("FAIL rstwait_nostrobe got %0d exp 0", k); end
      push(8'h43);
      fe_data_rq = 1'b1;
      wait_strobe(40, cyc, d);
      checks++; if (d !== 32'h0000_0043) begin errors++; $display("FAIL rstwrite_data got %h exp 00000043", d); end
      reset = 1'b1; fe_data_rq = 1'b0;
      tick();
      reset = 1'b0;
      checks++; if (s_write !== 1'b0)  begin errors++; $display("FAIL rstwrite_swrite got %0b exp 0", s_write); end
      checks++; if (h_count !== 16'd0) begin errors++; $display("FAIL rstwrite_count got %0d exp 0", h_count); end
      checks++; if (h_level !== 3'd0)  begin errors++; $display("FAIL rstwrite_level got %0d exp 0", h_level); end
   endtask

   initial begin
      reset = 1'b1; h_write = 1'b0; h_writedata = '0; h_flush = 1'b0;
      h_clr_flags = 1'b0; fe_data_rq = 1'b0;
      test_reset();
      test_single();
      test_multi();
      test_starve();
      test_full();
      test_abort();
      test_flush_wait();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
